// File: rtl/square_wave_generator.sv
// square_wave_generator: programmable 50 %-duty square-wave source whose half-period comes from a
// sequential restoring divider (CLK_FREQ / (2*freq)). Define BURST_MODE_EN to add burst_len/burst_done.
module square_wave_generator #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] freq_set,
  input  logic             load,
  input  logic             enable,
`ifdef BURST_MODE_EN
  input  logic [15:0]      burst_len,
  output logic             burst_done,
`endif
  output logic             signal_out,
  output logic [WIDTH-1:0] half_period,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int unsigned       ITER_W    = $clog2(WIDTH + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH);
  localparam logic [WIDTH-1:0]  DIVIDEND  = WIDTH'(CLK_FREQ);
  localparam logic [WIDTH-1:0]  MAX_FREQ  = WIDTH'(CLK_FREQ / 2);

  logic [1:0]        state;
  logic [WIDTH:0]    divisor;
  logic [WIDTH:0]    rem;
  logic [WIDTH-1:0]  quo;
  logic [ITER_W-1:0] iter;
  logic [WIDTH-1:0]  counter;

  logic              load_legal;
  logic              illegal_load;
  logic              commit;
  logic [WIDTH+1:0]  rem_shift;
  logic [WIDTH:0]    rem_diff;
  logic [WIDTH:0]    rem_next;
  logic              rem_ge;
  logic [WIDTH-1:0]  quo_next;

  logic              halted;
  logic              wave_hold;
  logic              wave_toggle;

  // NOTE: every signal written in an always_comb is assigned on every path (defaults first),
  // so no combination of inputs can leave it holding a value and infer a latch.
  always_comb begin
    load_legal   = (freq_set != '0) && (freq_set <= MAX_FREQ);
    illegal_load = load && !load_legal;
    commit       = !load && (state == ST_DIV) && (iter == ITER_LAST);

    // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    rem_shift = {rem, quo[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, divisor};
    rem_diff  = rem_shift[WIDTH:0] - divisor;
    rem_next  = rem_ge ? rem_diff : rem_shift[WIDTH:0];
    quo_next  = {quo[WIDTH-2:0], rem_ge};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values,
  // independent of statement order inside or across always_ff blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      iter        <= '0;
      half_period <= '0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (load) begin
        if (load_legal) begin
          state    <= ST_DIV;
          cfg_busy <= 1'b1;
          cfg_err  <= 1'b0;
          divisor  <= {freq_set, 1'b0};
          rem      <= '0;
          quo      <= DIVIDEND;
          iter     <= '0;
        end else begin
          state       <= ST_IDLE;
          cfg_busy    <= 1'b0;
          cfg_err     <= 1'b1;
          half_period <= '0;
        end
      end else if (state == ST_DIV) begin
        if (iter == ITER_LAST) begin
          state       <= ST_RUN;
          cfg_busy    <= 1'b0;
          cfg_done    <= 1'b1;
          half_period <= quo;
        end else begin
          rem  <= rem_next;
          quo  <= quo_next;
          iter <= iter + ITER_W'(1);
        end
      end
    end
  end

  // A non-zero half_period means a valid period exists; it keeps driving the output while a
  // reload is still dividing.
  always_comb begin
    wave_hold   = illegal_load || !enable || halted;
    wave_toggle = !wave_hold && !commit && (half_period != '0) &&
                  (counter == half_period - WIDTH'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter    <= '0;
      signal_out <= 1'b0;
    end else if (wave_hold) begin
      counter    <= '0;
      signal_out <= 1'b0;
    end else if (commit) begin
      counter <= '0;
    end else if (half_period != '0) begin
      if (wave_toggle) begin
        counter    <= '0;
        signal_out <= ~signal_out;
      end else begin
        counter <= counter + WIDTH'(1);
      end
    end
  end

`ifdef BURST_MODE_EN
  logic [15:0] burst_len_q;
  logic [15:0] pulse_cnt;

  // Rising edges are counted; the falling edge after the burst_len-th rise halts the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_len_q <= '0;
      pulse_cnt   <= '0;
      halted      <= 1'b0;
      burst_done  <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (load && load_legal) begin
        burst_len_q <= burst_len;
      end
      if (illegal_load || commit || !enable) begin
        pulse_cnt <= '0;
        halted    <= 1'b0;
      end else if (wave_toggle) begin
        if (!signal_out) begin
          pulse_cnt <= pulse_cnt + 16'd1;
        end else if ((burst_len_q != '0) && (pulse_cnt == burst_len_q)) begin
          halted     <= 1'b1;
          burst_done <= 1'b1;
        end
      end
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/square_wave_generator.md
Name: square_wave_generator

Overview:
Programmable square-wave source, the stimulus end of the frequency-measurement path. It takes a target frequency in Hz and computes the half-period in clock cycles with an on-chip sequential divider. It then drives a 50 %-duty square wave that the input-capture/frequency-counter block measures. Used for on-board self-test loopback and as a synthesisable replacement for bench-generated stimulus.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; the divider dividend.
WIDTH, 32, width of the frequency word and the half-period counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset: 0 = reset.
freq_set  input  WIDTH  requested output frequency in Hz; sampled on load.
load  input  1  one-cycle strobe; latch freq_set and start the divide.
enable  input  1  level; 1 = output toggles, 0 = output held low.
signal_out  output  1  generated square wave (registered).
half_period  output  WIDTH  current half-period in clk cycles (registered).
cfg_busy  output  1  high while the divider runs.
cfg_done  output  1  one-cycle pulse when a new half_period is committed.
cfg_err  output  1  sticky; set on an illegal freq_set, cleared by the next legal load.

Behaviour:
- Reset values (rst=0, async): signal_out=0, half_period=0, cfg_busy=0, cfg_done=0, cfg_err=0, counter=0, state=IDLE.
- States:
  - IDLE: no valid period; signal_out=0.
  - DIV: divider running.
  - RUN: valid period; output active when enable=1.
- Legality check on load: freq_set==0, or freq_set > CLK_FREQ/2, is illegal. On an illegal load: cfg_err<=1, half_period<=0, signal_out<=0, state<=IDLE, no cfg_done.
- Legal load, from any state:
  - freq latched; cfg_busy<=1; state<=DIV.
  - Restoring divide of CLK_FREQ by (2*freq), with a WIDTH+1-bit divisor, one quotient bit per cycle, WIDTH iterations.
  - Result is floor(CLK_FREQ/(2*freq)); the remainder is discarded.
- Latency: load sampled at edge N gives cfg_done=1 and the new half_period visible after edge N+WIDTH+1 (33 cycles at default). cfg_busy drops in the same cycle. State<=RUN.
- load during DIV: the divide aborts and restarts with the new freq_set. No cfg_done is issued for the aborted value.
- load during RUN:
  - The output keeps toggling at the old half_period until the new cfg_done.
  - At cfg_done the counter clears to 0; signal_out keeps its current level.
- RUN with enable=1:
  - Counter increments each cycle.
  - When counter==half_period-1: counter<=0 and signal_out toggles.
  - Output period = 2*half_period cycles, duty exactly 50 %.
- Phase: entering active RUN with counter=0 and signal_out=0, the first rising edge of signal_out occurs half_period cycles later.
- enable=0: next edge sets counter<=0 and signal_out<=0. half_period is retained. Re-asserting enable restarts from that phase.
- half_period==1, i.e. freq=CLK_FREQ/2: signal_out toggles every cycle.
- Reset mid-DIV or mid-RUN: all state is returned to reset values immediately. No cfg_done.

Optional Feature:
Macro BURST_MODE_EN.
- Defined:
  - Adds input burst_len[15:0], sampled on load, and output burst_done (one-cycle pulse, reset 0).
  - burst_len==0 means continuous operation.
  - Otherwise, each rising edge of signal_out is counted. After the falling edge that ends the burst_len-th period, signal_out holds 0 and burst_done pulses for one cycle. The block then stays in a halted RUN state.
  - The next burst is armed by a new load, or by enable going 0 then 1.
- Not defined: the ports are absent and operation is always continuous.

Test Plan:
- Reset release, load freq_set=1000, enable=1 -> cfg_done exactly 33 cycles after load; half_period=25000; signal_out rises 25000 cycles after cfg_done; measured period 50000 cycles.
- freq_set=3 -> half_period=8_333_333 (floor). freq_set=25_000_000 -> half_period=1, signal_out toggles every cycle.
- freq_set=0, then separately freq_set=25_000_001 -> cfg_err=1, signal_out stays 0, no cfg_done. A following load of 1000 clears cfg_err.
- load 1000, then load 500 ten cycles later during DIV -> single cfg_done 33 cycles after the second load, half_period=50000.
- Running at 1000; drop enable for 100 cycles, then reassert -> signal_out=0 one cycle after the drop; first rising edge 25000 cycles after reassertion.
- BURST_MODE_EN, burst_len=3, freq_set=1_000_000 (half_period 25) -> exactly 3 high pulses of 25 cycles, then burst_done pulses once and signal_out stays 0. Assert rst mid-burst -> all outputs 0 immediately.
